controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Multi-cycle control unit; drives the RV64I datapath from the opposite side of its control interface.
- Consumes `upcode`, `funct3`, `funct7[5]` and the ALU flags that the datapath exports.
- Produces every datapath control strobe: `soma_ou_subtrai`, `select_imm`, `usa_imm`, `we_reg`, and the PC/IR/memory enables.
- Sequences FETCH → DECODE → EXEC → MEM → WB, with a ready handshake toward unified instruction/data memory.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- RESET_STATE_TRAP, 0, if 1, an illegal opcode holds TRAP until reset; if 0, it skips the instruction (PC+4) and asserts `illegal` for one cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- upcode  in  7  instr[6:0] from datapath
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- flag_igual  in  1  ALU equal flag
- flag_menor  in  1  ALU signed-less flag
- flag_maior_igual_u  in  1  ALU unsigned ≥ flag
- mem_ready  in  1  memory completed the current request
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write (store)
- ir_we  out  1  instruction register load
- pc_we  out  1  PC update
- pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result & ~1
- we_reg  out  1  register-file write enable
- wb_sel  out  2  0=ALU, 1=memory, 2=PC+4, 3=imm
- select_imm  out  3  I=0, J=1, U=2, B=3, S=4
- usa_imm  out  1  ALU B operand = immediate
- soma_ou_subtrai  out  2  0=nao, 1=soma, 2=subtrai
- illegal  out  1  illegal opcode/funct3 detected
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; retired=0; illegal=0.
  - All strobes 0 during reset and in the first cycle after release, until FETCH logic runs.
  - Reset mid-operation drops `mem_req` immediately; no register/PC write completes.
- Strobes:
  - Default value is 0 in every state not listed.
  - `soma_ou_subtrai`=nao outside EXEC/MEM.
- FETCH:
  - `mem_req`=1, `mem_we`=0.
  - `mem_ready`=0: stay in FETCH.
  - `mem_ready`=1: `ir_we`=1 in that same cycle (Mealy), next=DECODE.
- DECODE (1 cycle):
  - Sets `select_imm` by opcode: LOAD/OP-IMM/JALR=I, STORE=S, BRANCH=B, LUI/AUIPC=U, JAL=J.
  - Unknown opcode, or BRANCH with funct3 010/011 → `illegal`; next=TRAP or EXEC-skip, depending on RESET_STATE_TRAP.
- EXEC:
  - ALU op:
    - OP with funct3=000 and funct7_5=1 → subtrai.
    - BRANCH → subtrai.
    - All others → soma.
  - `usa_imm`=1 for all but OP/BRANCH.
  - BRANCH resolves here:
    - Taken when BEQ:`flag_igual`, BNE:!`flag_igual`, BLT:`flag_menor`, BGE:!`flag_menor`, BLTU:!`flag_maior_igual_u`, BGEU:`flag_maior_igual_u`.
    - `pc_we`=1 with `pc_src`=taken?1:0; next=FETCH.
  - LOAD/STORE → MEM; others → WB.
- MEM:
  - `mem_req`=1, `mem_we`=(STORE); `soma_ou_subtrai`=soma held so the address stays stable.
  - Wait for `mem_ready`.
  - STORE on ready: `pc_we`=1, `pc_src`=0, next=FETCH.
  - LOAD on ready: next=WB.
- WB:
  - `we_reg`=1; `pc_we`=1.
  - `wb_sel`: LOAD=1, JAL/JALR=2, LUI=3, others=0.
  - `pc_src`: JAL=1, JALR=2, else 0.
  - next=FETCH.
- TRAP: all strobes 0, `illegal`=1, absorbing until reset.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle):
  - Branch: 3 cycles.
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- `retired`:
  - Increments on every cycle with `pc_we`=1.
  - Wraps from 2^CNT_W−1 to 0.
  - Not incremented in TRAP.
- `mem_ready` is ignored outside FETCH/MEM.
- Inputs are sampled only in DECODE/EXEC/WB; the datapath holds IR stable from DECODE until the next FETCH.

Decomposition:
- Package `controle_pkg`:
  - Opcode constants (LOAD, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL).
  - State enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}.
  - `select_imm` encodings I/J/U/B/S.
  - `soma_ou_subtrai` encodings nao/soma/subtrai.
  - `pc_src` and `wb_sel` encodings.
- One combinational sub-module, `avalia_desvio`: funct3 + flags → taken/invalid.

Test Plan:
- ADD (0110011, f3=000, f7_5=0), `mem_ready` tied 1:
  - FETCH asserts `ir_we`; EXEC shows `soma_ou_subtrai`=1, `usa_imm`=0.
  - WB shows `we_reg`=1, `wb_sel`=0, `pc_src`=0.
  - `retired`=1 after 4 cycles.
- SUB (f7_5=1) → EXEC `soma_ou_subtrai`=2. BEQ with `flag_igual`=1 → `pc_we`/`pc_src`=1 in cycle 3, `we_reg` never 1. BGEU with `flag_maior_igual_u`=0 → `pc_src`=0.
- LW with `mem_ready` low for 3 MEM cycles:
  - `mem_req` stays 1 and `mem_we`=0 throughout.
  - WB follows the ready cycle with `wb_sel`=1; total 8 cycles.
- SD:
  - MEM shows `mem_we`=1, `select_imm` latched S(4).
  - `pc_we` in the ready cycle; `we_reg` stays 0.
- Opcode 0000000 with RESET_STATE_TRAP=1:
  - Enters TRAP; `illegal`=1; no further `mem_req`.
  - `rst_n` pulse low → FETCH, `illegal`=0, `retired`=0.
- Reset asserted in MEM mid-load → `mem_req` drops asynchronously, no `we_reg`; after release, fetch restarts. CNT_W=4 with 16 retired → wraps to 0.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle RV64I control unit: opcodes, FSM states
// and the select codes driven toward the datapath.
package controle_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} estado_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_J = 3'd1,
    IMM_U = 3'd2,
    IMM_B = 3'd3,
    IMM_S = 3'd4
  } imm_t;

  typedef enum logic [1:0] {ALU_NAO = 2'd0, ALU_SOMA = 2'd1, ALU_SUBTRAI = 2'd2} alu_op_t;

  localparam logic [1:0] PC_MAIS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  function automatic imm_t imm_de(input logic [6:0] opc);
    case (opc)
      OPC_STORE:          imm_de = IMM_S;
      OPC_BRANCH:         imm_de = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_de = IMM_U;
      OPC_JAL:            imm_de = IMM_J;
      default:            imm_de = IMM_I;
    endcase
  endfunction

  function automatic logic opcode_valido(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: opcode_valido = 1'b1;
      default:                                opcode_valido = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/controle_multiciclo_avalia_desvio.sv
// Branch condition evaluator: maps funct3 and the ALU flags to a taken decision,
// flagging the two funct3 codes that have no branch meaning.
module avalia_desvio (
  input  logic [2:0] funct3,
  input  logic       flag_igual,
  input  logic       flag_menor,
  input  logic       flag_maior_igual_u,
  output logic       tomado,
  output logic       invalido
);

  always_comb begin
    tomado   = 1'b0;
    invalido = 1'b0;
    case (funct3)
      3'b000:  tomado = flag_igual;
      3'b001:  tomado = !flag_igual;
      3'b100:  tomado = flag_menor;
      3'b101:  tomado = !flag_menor;
      3'b110:  tomado = !flag_maior_igual_u;
      3'b111:  tomado = flag_maior_igual_u;
      default: invalido = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit for the RV64I datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing, strobe generation and a retired-instruction counter.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int CNT_W            = 32,
  parameter bit RESET_STATE_TRAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       upcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             flag_igual,
  input  logic             flag_menor,
  input  logic             flag_maior_igual_u,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             we_reg,
  output logic [1:0]       wb_sel,
  output logic [2:0]       select_imm,
  output logic             usa_imm,
  output logic [1:0]       soma_ou_subtrai,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  estado_t    estado;
  logic       ativo;
  logic [6:0] op_q;
  imm_t       imm_q;
  logic       desvio_tomado;
  logic       desvio_invalido;
  logic       instr_ilegal;
  logic       e_load, e_store, e_branch, e_op, e_jal, e_jalr, e_lui;

  avalia_desvio u_avalia_desvio (
    .funct3             (funct3),
    .flag_igual         (flag_igual),
    .flag_menor         (flag_menor),
    .flag_maior_igual_u (flag_maior_igual_u),
    .tomado             (desvio_tomado),
    .invalido           (desvio_invalido)
  );

  assign instr_ilegal = !opcode_valido(upcode) || (upcode == OPC_BRANCH && desvio_invalido);

  assign e_load   = (op_q == OPC_LOAD);
  assign e_store  = (op_q == OPC_STORE);
  assign e_branch = (op_q == OPC_BRANCH);
  assign e_op     = (op_q == OPC_OP);
  assign e_jal    = (op_q == OPC_JAL);
  assign e_jalr   = (op_q == OPC_JALR);
  assign e_lui    = (op_q == OPC_LUI);

  // ativo keeps every strobe low for the first cycle after reset release.
  // In EXEC, illegal doubles as the skip marker for a rejected instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= FETCH;
      ativo   <= 1'b0;
      op_q    <= '0;
      imm_q   <= IMM_I;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      ativo <= 1'b1;
      if (pc_we) retired <= retired + CNT_W'(1);
      unique case (estado)
        FETCH: if (ativo && mem_ready) estado <= DECODE;
        DECODE: begin
          op_q  <= upcode;
          imm_q <= imm_de(upcode);
          if (instr_ilegal) begin
            illegal <= 1'b1;
            estado  <= RESET_STATE_TRAP ? TRAP : EXEC;
          end else begin
            estado <= EXEC;
          end
        end
        EXEC: begin
          illegal <= 1'b0;
          if (illegal || e_branch)  estado <= FETCH;
          else if (e_load || e_store) estado <= MEM;
          else                      estado <= WB;
        end
        MEM: if (mem_ready) estado <= e_store ? FETCH : WB;
        WB:      estado <= FETCH;
        default: estado <= TRAP;
      endcase
    end
  end

  // Memory handshake: mem_req stays high with a stable mem_we (and, in MEM, a stable
  // ALU address) until a cycle where mem_ready is high; that cycle completes the access.
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    ir_we           = 1'b0;
    pc_we           = 1'b0;
    pc_src          = PC_MAIS4;
    we_reg          = 1'b0;
    wb_sel          = WB_ALU;
    select_imm      = IMM_I;
    usa_imm         = 1'b0;
    soma_ou_subtrai = ALU_NAO;
    unique case (estado)
      FETCH: begin
        if (ativo) begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
      end
      DECODE: select_imm = imm_de(upcode);
      EXEC: begin
        if (illegal) begin
          pc_we = 1'b1;
        end else begin
          select_imm      = imm_q;
          soma_ou_subtrai = (e_branch || (e_op && funct3 == 3'b000 && funct7_5)) ? ALU_SUBTRAI : ALU_SOMA;
          usa_imm         = !(e_op || e_branch);
          if (e_branch) begin
            pc_we  = 1'b1;
            pc_src = desvio_tomado ? PC_IMM : PC_MAIS4;
          end
        end
      end
      MEM: begin
        mem_req         = 1'b1;
        mem_we          = e_store;
        select_imm      = imm_q;
        usa_imm         = 1'b1;
        soma_ou_subtrai = ALU_SOMA;
        if (mem_ready && e_store) pc_we = 1'b1;
      end
      WB: begin
        we_reg     = 1'b1;
        pc_we      = 1'b1;
        select_imm = imm_q;
        wb_sel     = e_load ? WB_MEM : (e_jal || e_jalr) ? WB_PC4 : e_lui ? WB_IMM : WB_ALU;
        pc_src     = e_jal ? PC_IMM : e_jalr ? PC_ALU : PC_MAIS4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction cycle plans built from the ISA
// rules, replayed against a skip-mode unit (CNT_W=4) and a trap-mode unit (CNT_W=32).
module tb_controle_multiciclo;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       we_reg;
    logic [1:0] wb_sel;
    logic [2:0] select_imm;
    logic       usa_imm;
    logic [1:0] soma_ou_subtrai;
    logic       illegal;
  } sb_t;

  localparam int SB_W = $bits(sb_t);

  typedef struct packed {
    logic [6:0] upcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       fi;
    logic       fm;
    logic       fu;
    logic       mr;
    sb_t        exp;
  } passo_t;

  localparam logic [6:0] L_LOAD   = 7'b0000011;
  localparam logic [6:0] L_OP_IMM = 7'b0010011;
  localparam logic [6:0] L_AUIPC  = 7'b0010111;
  localparam logic [6:0] L_STORE  = 7'b0100011;
  localparam logic [6:0] L_OP     = 7'b0110011;
  localparam logic [6:0] L_LUI    = 7'b0110111;
  localparam logic [6:0] L_BRANCH = 7'b1100011;
  localparam logic [6:0] L_JALR   = 7'b1100111;
  localparam logic [6:0] L_JAL    = 7'b1101111;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] upcode;
  logic [2:0] funct3;
  logic       funct7_5, flag_igual, flag_menor, flag_maior_igual_u, mem_ready;

  logic       mem_req, mem_we, ir_we, pc_we, we_reg, usa_imm, illegal;
  logic [1:0] pc_src, wb_sel, soma_ou_subtrai;
  logic [2:0] select_imm;
  logic [3:0] retired;

  logic        t_mem_req, t_mem_we, t_ir_we, t_pc_we, t_we_reg, t_usa_imm, t_illegal;
  logic [1:0]  t_pc_src, t_wb_sel, t_soma_ou_subtrai;
  logic [2:0]  t_select_imm;
  logic [31:0] t_retired;

  controle_multiciclo #(.CNT_W(4), .RESET_STATE_TRAP(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .upcode(upcode), .funct3(funct3), .funct7_5(funct7_5),
    .flag_igual(flag_igual), .flag_menor(flag_menor), .flag_maior_igual_u(flag_maior_igual_u),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .we_reg(we_reg), .wb_sel(wb_sel), .select_imm(select_imm),
    .usa_imm(usa_imm), .soma_ou_subtrai(soma_ou_subtrai), .illegal(illegal), .retired(retired)
  );

  controle_multiciclo #(.CNT_W(32), .RESET_STATE_TRAP(1'b1)) u_trap (
    .clk(clk), .rst_n(rst_n), .upcode(upcode), .funct3(funct3), .funct7_5(funct7_5),
    .flag_igual(flag_igual), .flag_menor(flag_menor), .flag_maior_igual_u(flag_maior_igual_u),
    .mem_ready(mem_ready), .mem_req(t_mem_req), .mem_we(t_mem_we), .ir_we(t_ir_we),
    .pc_we(t_pc_we), .pc_src(t_pc_src), .we_reg(t_we_reg), .wb_sel(t_wb_sel),
    .select_imm(t_select_imm), .usa_imm(t_usa_imm), .soma_ou_subtrai(t_soma_ou_subtrai),
    .illegal(t_illegal), .retired(t_retired)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ret = 0;
  bit          b_em_trap = 1'b0;
  logic [31:0] ret_b_trap = '0;
  logic [SB_W-1:0] exp_q[$];
  int          ret_q[$];
  sb_t         obs_q[$];
  passo_t      passos[$];

  task automatic verifica(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    n_cmp++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, obtido, esperado, $time);
    end
  endtask

  // scoreboard: one expected record per driven cycle, checked on the falling edge
  always @(negedge clk) begin : compara
    sb_t va, vb, e, vt;
    int  r;
    va = '{mem_req, mem_we, ir_we, pc_we, pc_src, we_reg, wb_sel, select_imm, usa_imm,
           soma_ou_subtrai, illegal};
    vb = '{t_mem_req, t_mem_we, t_ir_we, t_pc_we, t_pc_src, t_we_reg, t_wb_sel, t_select_imm,
           t_usa_imm, t_soma_ou_subtrai, t_illegal};
    vt = '0;
    vt.illegal = 1'b1;
    obs_q.push_back(va);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = ret_q.pop_front();
      verifica("strobes_skip", 32'(va), 32'(e));
      verifica("retired_skip", 32'(retired), 32'(r % 16));
      if (b_em_trap) begin
        verifica("strobes_trap_held", 32'(vb), 32'(vt));
        verifica("retired_trap_held", t_retired, ret_b_trap);
      end else begin
        verifica("strobes_trap", 32'(vb), 32'(e));
        verifica("retired_trap", t_retired, 32'(r));
      end
    end
  end

  // behavioural plan of one instruction, cycle by cycle, from the ISA rules
  task automatic monta(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, input int fw, input int mw);
    passo_t p;
    logic ld, st, br, op, jal, jalr, lui, auipc, opimm, legal, taken, sub;
    logic [2:0] imm;
    ld = (opc == L_LOAD);   st = (opc == L_STORE); br = (opc == L_BRANCH);
    op = (opc == L_OP);     jal = (opc == L_JAL);  jalr = (opc == L_JALR);
    lui = (opc == L_LUI);   auipc = (opc == L_AUIPC); opimm = (opc == L_OP_IMM);
    legal = (ld | st | br | op | jal | jalr | lui | auipc | opimm) && !(br && (f3 == 3'd2 || f3 == 3'd3));
    imm = st ? 3'd4 : br ? 3'd3 : (lui | auipc) ? 3'd2 : jal ? 3'd1 : 3'd0;
    case (f3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = ($signed(a) < $signed(b));
      3'd5:    taken = ($signed(a) >= $signed(b));
      3'd6:    taken = (a < b);
      3'd7:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
    sub = br || (op && f3 == 3'd0 && f7);
    p = '0;
    p.funct7_5 = f7;
    p.fi = (a == b);
    p.fm = ($signed(a) < $signed(b));
    p.fu = (a >= b);
    for (int i = 0; i < fw; i++) begin
      p.upcode = 7'($urandom); p.funct3 = 3'($urandom); p.mr = 1'b0;
      p.exp = '0; p.exp.mem_req = 1'b1;
      passos.push_back(p);
    end
    p.upcode = 7'($urandom); p.funct3 = 3'($urandom); p.mr = 1'b1;
    p.exp = '0; p.exp.mem_req = 1'b1; p.exp.ir_we = 1'b1;
    passos.push_back(p);
    p.upcode = opc; p.funct3 = f3;
    p.mr = 1'($urandom_range(0, 1));
    p.exp = '0; p.exp.select_imm = imm;
    passos.push_back(p);
    if (!legal) begin
      p.mr = 1'($urandom_range(0, 1));
      p.exp = '0; p.exp.pc_we = 1'b1; p.exp.illegal = 1'b1;
      passos.push_back(p);
      return;
    end
    p.mr = 1'($urandom_range(0, 1));
    p.exp = '0; p.exp.select_imm = imm;
    p.exp.soma_ou_subtrai = sub ? 2'd2 : 2'd1;
    p.exp.usa_imm = !(op || br);
    if (br) begin
      p.exp.pc_we = 1'b1;
      p.exp.pc_src = {1'b0, taken};
    end
    passos.push_back(p);
    if (br) return;
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        p.mr = (i == mw);
        p.exp = '0; p.exp.mem_req = 1'b1; p.exp.mem_we = st; p.exp.soma_ou_subtrai = 2'd1;
        p.exp.usa_imm = 1'b1; p.exp.select_imm = imm;
        p.exp.pc_we = st && (i == mw);
        passos.push_back(p);
      end
      if (st) return;
    end
    p.mr = 1'($urandom_range(0, 1));
    p.exp = '0; p.exp.we_reg = 1'b1; p.exp.pc_we = 1'b1; p.exp.select_imm = imm;
    p.exp.wb_sel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
    p.exp.pc_src = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    passos.push_back(p);
  endtask

  // driver: plays n planned cycles starting just after a rising edge
  task automatic play(input int n);
    passo_t p;
    for (int i = 0; i < n && passos.size() > 0; i++) begin
      p = passos.pop_front();
      upcode = p.upcode; funct3 = p.funct3; funct7_5 = p.funct7_5;
      flag_igual = p.fi; flag_menor = p.fm; flag_maior_igual_u = p.fu; mem_ready = p.mr;
      exp_q.push_back(p.exp);
      ret_q.push_back(n_ret);
      if (p.exp.pc_we) n_ret++;
      @(posedge clk); #1;
    end
  endtask

  task automatic reinicia();
    passos.delete();
    rst_n = 1'b0;
    b_em_trap = 1'b0;
    n_ret = 0;
    mem_ready = 1'b1;
    #1;
    verifica("reset_async_mem_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0); ret_q.push_back(0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    exp_q.push_back('0); ret_q.push_back(0);
    @(posedge clk); #1;
  endtask

  task automatic aleatoria(input bit permite_ilegal);
    logic [6:0]  tab [9];
    logic [2:0]  f3b [6];
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] a, b;
    tab = '{L_LOAD, L_OP_IMM, L_AUIPC, L_STORE, L_OP, L_LUI, L_BRANCH, L_JALR, L_JAL};
    f3b = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    opc = tab[$urandom_range(0, 8)];
    f3 = 3'($urandom);
    if (opc == L_BRANCH) f3 = f3b[$urandom_range(0, 5)];
    if (permite_ilegal && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 1) == 0) opc = 7'($urandom);
      else begin opc = L_BRANCH; f3 = 3'($urandom_range(2, 3)); end
    end
    a = {$urandom, $urandom};
    b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
    monta(opc, f3, 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), $urandom_range(0, 3));
    play(100);
  endtask

  initial begin
    int  w;
    upcode = '0; funct3 = '0; funct7_5 = 1'b0; flag_igual = 1'b0; flag_menor = 1'b0;
    flag_maior_igual_u = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reinicia();

    obs_q.delete(); monta(L_OP, 3'd0, 1'b0, 64'd7, 64'd3, 0, 0); play(100);
    verifica("add_fetch_ir_we", 32'(obs_q[0].ir_we), 32'd1);
    verifica("add_exec_soma", 32'(obs_q[2].soma_ou_subtrai), 32'd1);
    verifica("add_exec_usa_imm", 32'(obs_q[2].usa_imm), 32'd0);
    verifica("add_wb_we_reg", 32'(obs_q[3].we_reg), 32'd1);
    verifica("add_wb_sel", 32'(obs_q[3].wb_sel), 32'd0);
    verifica("add_retired", 32'(retired), 32'd1);

    obs_q.delete(); monta(L_OP, 3'd0, 1'b1, 64'd7, 64'd3, 0, 0); play(100);
    verifica("sub_exec_subtrai", 32'(obs_q[2].soma_ou_subtrai), 32'd2);

    obs_q.delete(); monta(L_BRANCH, 3'd0, 1'b0, 64'd5, 64'd5, 0, 0); play(100);
    verifica("beq_taken_pc_we", 32'(obs_q[2].pc_we), 32'd1);
    verifica("beq_taken_pc_src", 32'(obs_q[2].pc_src), 32'd1);
    w = 0;
    foreach (obs_q[i]) w += obs_q[i].we_reg;
    verifica("beq_no_we_reg", 32'(w), 32'd0);

    obs_q.delete(); monta(L_BRANCH, 3'd7, 1'b0, 64'd1, 64'd2, 0, 0); play(100);
    verifica("bgeu_not_taken_pc_src", 32'(obs_q[2].pc_src), 32'd0);

    obs_q.delete(); monta(L_LOAD, 3'd2, 1'b0, 64'd0, 64'd0, 0, 3); play(100);
    for (int i = 3; i <= 6; i++) verifica("lw_mem_req_held", 32'({obs_q[i].mem_req, obs_q[i].mem_we}), 32'd2);
    verifica("lw_wb_sel_cycle8", 32'({obs_q[7].we_reg, obs_q[7].wb_sel}), 32'd5);

    obs_q.delete(); monta(L_STORE, 3'd3, 1'b0, 64'd0, 64'd0, 0, 0); play(100);
    verifica("sd_mem_we", 32'(obs_q[3].mem_we), 32'd1);
    verifica("sd_select_imm_s", 32'(obs_q[3].select_imm), 32'd4);
    verifica("sd_pc_we_ready", 32'(obs_q[3].pc_we), 32'd1);
    w = 0;
    foreach (obs_q[i]) w += obs_q[i].we_reg;
    verifica("sd_no_we_reg", 32'(w), 32'd0);

    for (int k = 0; k < 60; k++) aleatoria(1'b0);

    reinicia();
    for (int k = 0; k < 16; k++) begin
      monta(L_OP_IMM, 3'd0, 1'b0, 64'd1, 64'd2, 0, 0); play(100);
    end
    verifica("wrap_cnt4", 32'(retired), 32'd0);
    verifica("no_wrap_cnt32", t_retired, 32'd16);

    monta(L_LOAD, 3'd3, 1'b0, 64'd0, 64'd0, 0, 5); play(5);
    reinicia();
    monta(L_OP, 3'd0, 1'b0, 64'd9, 64'd9, 1, 0); play(100);
    verifica("restart_after_mid_load_reset", 32'(retired), 32'd1);

    monta(7'b0000000, 3'd0, 1'b0, 64'd0, 64'd0, 0, 0); play(2);
    b_em_trap = 1'b1;
    ret_b_trap = 32'(n_ret);
    play(100);
    verifica("trap_illegal_high", 32'(t_illegal), 32'd1);
    for (int k = 0; k < 30; k++) aleatoria(1'b1);
    reinicia();
    verifica("trap_cleared_illegal", 32'(t_illegal), 32'd0);
    verifica("trap_cleared_retired", t_retired, 32'd0);
    for (int k = 0; k < 10; k++) aleatoria(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
